multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback for one instruction at a time, driven by the decoded opcode class and system kind. It owns the single shared memory port handshake, PC/IR/regfile write enables, trap entry, the bus watchdog and the retired-instruction counter. It sits between the decoder and the datapath muxes.

Parameters:
MEM_TIMEOUT, 255, max cycles spent in any memory wait state before a bus-timeout trap (>=1)
CNT_W, 32, width of instret counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
opcode_i  in  4  opcode class: 0 invalid, 1 lui, 2 auipc, 3 jal, 4 jalr, 5 branch, 6 load, 7 store, 8 imm_arith, 9 reg_arith, 10 fence, 11 system; 12-15 treated as invalid
sys_kind_i  in  4  system kind: 0 invalid, 1 ecall, 2 ebreak, 3-8 csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci; 9-15 invalid
branch_taken_i  in  1  branch comparator result, valid in EXEC
mem_gnt_i  in  1  memory accepted request this cycle
mem_rvalid_i  in  1  memory response (read data or store ack)
mem_req_o  out  1  memory request
mem_we_o  out  1  request is a store
mem_addr_sel_o  out  1  0 = PC, 1 = ALU result
ir_we_o  out  1  latch instruction register
rf_we_o  out  1  register file write
rf_src_o  out  2  0 ALU, 1 load data, 2 PC+4, 3 CSR read data
csr_we_o  out  1  CSR write strobe
pc_we_o  out  1  PC write
pc_sel_o  out  2  0 PC+4, 1 target, 2 trap vector
trap_valid_o  out  1  one-cycle trap pulse
trap_cause_o  out  2  0 illegal, 1 ecall, 2 ebreak, 3 bus timeout
instret_o  out  CNT_W  retired instruction count
state_o  out  3  current state encoding

Behaviour:
- States (encoding): FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MEM=4, MWAIT=5, WB=6, TRAP=7. All outputs Moore except where stated.
- Reset: state FETCH, instret 0, watchdog 0, every output 0 (mem_req_o rises in the first cycle after reset release). Reset in any state, including mid-handshake, aborts immediately; late gnt/rvalid after reset are ignored.
- FETCH: mem_req_o=1, mem_we_o=0, addr_sel=0; held until mem_gnt_i, then FWAIT.
- FWAIT: on mem_rvalid_i: ir_we_o=1 (Mealy, same cycle), go DECODE.
- DECODE: invalid opcode, or system with invalid sys_kind -> TRAP cause 0; system ecall -> TRAP cause 1; ebreak -> TRAP cause 2; fence -> WB; otherwise EXEC.
- EXEC: load/store -> MEM. Branch -> pc_we_o=1, pc_sel_o = branch_taken_i ? 1 : 0, retire, go FETCH. All others -> WB.
- MEM: mem_req_o=1, addr_sel=1, mem_we_o=1 iff store; hold until gnt, then MWAIT.
- MWAIT: on rvalid: load -> WB; store -> pc_we_o=1, pc_sel=0, retire, go FETCH.
- WB: pc_we_o=1. pc_sel=1 for jal/jalr, else 0. rf_we_o=1 with rf_src: lui/auipc/arith=0, load=1, jal/jalr=2, csr=3. For csr, csr_we_o=1. Fence: pc_we only. Retire, go FETCH.
- TRAP: trap_valid_o=1, trap_cause_o held from entry, pc_we_o=1, pc_sel=2; no retire; next FETCH.
- Watchdog: counts each cycle in FETCH, FWAIT, MEM or MWAIT; cleared on leaving them. When it reaches MEM_TIMEOUT without the awaited event -> TRAP cause 3. The event arriving on the timeout cycle wins (no trap).
- gnt outside FETCH/MEM and rvalid outside FWAIT/MWAIT are ignored.
- instret increments by 1 on each retire cycle; wraps modulo 2^CNT_W.

Test Plan:
- ADDI, gnt same cycle as req, rvalid next cycle -> states 0,1,2,3,6; rf_we with src 0 and pc_we in WB; instret 0->1; 5 cycles total.
- LW, data gnt delayed 3 cycles and rvalid after 2 more -> mem_req held 4 cycles with addr_sel=1, we=0; WB rf_src=1; instret +1.
- BEQ with taken=1, then with taken=0 -> EXEC pc_we with pc_sel 1 and 0; no rf_we; next state FETCH.
- opcode_i=0, then system sys_kind=2 -> TRAP, trap_valid one cycle, causes 0 and 2, pc_sel=2, instret unchanged.
- MEM_TIMEOUT=4, gnt never asserted in FETCH -> TRAP cause 3 after 4 FETCH cycles; with gnt on the 4th cycle instead -> FWAIT, no trap.
- Store in MWAIT, rst for one cycle, then rvalid -> FETCH, instret 0, rvalid ignored, outputs 0 during reset.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Control FSM for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback
// sequencing, shared memory port handshake, trap entry, bus watchdog and instret.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode_i,
  input  logic [3:0]       sys_kind_i,
  input  logic             branch_taken_i,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_addr_sel_o,
  output logic             ir_we_o,
  output logic             rf_we_o,
  output logic [1:0]       rf_src_o,
  output logic             csr_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             trap_valid_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_MWAIT  = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] OP_INVALID = 4'd0;
  localparam logic [3:0] OP_JAL     = 4'd3;
  localparam logic [3:0] OP_JALR    = 4'd4;
  localparam logic [3:0] OP_BRANCH  = 4'd5;
  localparam logic [3:0] OP_LOAD    = 4'd6;
  localparam logic [3:0] OP_STORE   = 4'd7;
  localparam logic [3:0] OP_FENCE   = 4'd10;
  localparam logic [3:0] OP_SYSTEM  = 4'd11;

  localparam logic [3:0] SYS_ECALL  = 4'd1;
  localparam logic [3:0] SYS_EBREAK = 4'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam int              WD_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WD_W-1:0]   r_wdog;
  logic [CNT_W-1:0]  r_instret;
  logic [1:0]        r_cause;
  logic [1:0]        w_cause;
  logic              w_retire;
  logic              w_wd_hit;
  logic              w_illegal;

  logic       w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_rf_we, w_csr_we, w_pc_we, w_trap_valid;
  logic [1:0] w_rf_src, w_pc_sel;

  assign w_wd_hit  = (r_wdog == WD_LAST);
  assign w_illegal = (opcode_i == OP_INVALID) || (opcode_i >= 4'd12) ||
                     ((opcode_i == OP_SYSTEM) && ((sys_kind_i == 4'd0) || (sys_kind_i >= 4'd9)));

  always_comb begin
    w_next       = r_state;
    w_cause      = CAUSE_ILLEGAL;
    w_retire     = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    w_ir_we      = 1'b0;
    w_rf_we      = 1'b0;
    w_rf_src     = 2'd0;
    w_csr_we     = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_sel     = 2'd0;
    w_trap_valid = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_gnt_i) begin
          w_next = S_FWAIT;
        end else if (w_wd_hit) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_FWAIT: begin
        if (mem_rvalid_i) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_wd_hit) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_ILLEGAL;
        end else if ((opcode_i == OP_SYSTEM) && (sys_kind_i == SYS_ECALL)) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_ECALL;
        end else if ((opcode_i == OP_SYSTEM) && (sys_kind_i == SYS_EBREAK)) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_EBREAK;
        end else if (opcode_i == OP_FENCE) begin
          w_next = S_WB;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((opcode_i == OP_LOAD) || (opcode_i == OP_STORE)) begin
          w_next = S_MEM;
        end else if (opcode_i == OP_BRANCH) begin
          // Branches retire straight from EXEC; the comparator picks the PC source.
          w_pc_we  = 1'b1;
          w_pc_sel = branch_taken_i ? 2'd1 : 2'd0;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = (opcode_i == OP_STORE);
        if (mem_gnt_i) begin
          w_next = S_MWAIT;
        end else if (w_wd_hit) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_MWAIT: begin
        if (mem_rvalid_i) begin
          if (opcode_i == OP_STORE) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_wd_hit) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
        case (opcode_i)
          OP_JAL, OP_JALR: begin
            w_pc_sel = 2'd1;
            w_rf_we  = 1'b1;
            w_rf_src = 2'd2;
          end
          OP_LOAD: begin
            w_rf_we  = 1'b1;
            w_rf_src = 2'd1;
          end
          OP_SYSTEM: begin
            w_rf_we  = 1'b1;
            w_rf_src = 2'd3;
            w_csr_we = 1'b1;
          end
          OP_FENCE: ;
          default: w_rf_we = 1'b1;
        endcase
      end
      S_TRAP: begin
        w_trap_valid = 1'b1;
        w_pc_we      = 1'b1;
        w_pc_sel     = 2'd2;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Only the wait states ever self-loop, so a state change is exactly "left a wait state".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wdog    <= '0;
      r_instret <= '0;
      r_cause   <= CAUSE_ILLEGAL;
    end else begin
      r_state <= w_next;
      r_wdog  <= (w_next == r_state) ? r_wdog + 1'b1 : '0;
      if (w_retire) begin
        r_instret <= r_instret + 1'b1;
      end
      if (w_next == S_TRAP) begin
        r_cause <= w_cause;
      end
    end
  end

  // Reset forces every output low, including any handshake in flight.
  assign mem_req_o      = !rst && w_mem_req;
  assign mem_we_o       = !rst && w_mem_we;
  assign mem_addr_sel_o = !rst && w_addr_sel;
  assign ir_we_o        = !rst && w_ir_we;
  assign rf_we_o        = !rst && w_rf_we;
  assign rf_src_o       = rst ? 2'd0 : w_rf_src;
  assign csr_we_o       = !rst && w_csr_we;
  assign pc_we_o        = !rst && w_pc_we;
  assign pc_sel_o       = rst ? 2'd0 : w_pc_sel;
  assign trap_valid_o   = !rst && w_trap_valid;
  assign trap_cause_o   = (!rst && (r_state == S_TRAP)) ? r_cause : 2'd0;
  assign instret_o      = rst ? '0 : r_instret;
  assign state_o        = rst ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_sequencer;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       opcode_i = 4'd0;
  logic [3:0]       sys_kind_i = 4'd0;
  logic             branch_taken_i = 1'b0;
  logic             mem_gnt_i = 1'b0;
  logic             mem_rvalid_i = 1'b0;
  logic             mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, rf_we_o, csr_we_o, pc_we_o, trap_valid_o;
  logic [1:0]       rf_src_o, pc_sel_o, trap_cause_o;
  logic [CNT_W-1:0] instret_o;
  logic [2:0]       state_o;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .sys_kind_i(sys_kind_i),
    .branch_taken_i(branch_taken_i), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o),
    .ir_we_o(ir_we_o), .rf_we_o(rf_we_o), .rf_src_o(rf_src_o), .csr_we_o(csr_we_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .trap_valid_o(trap_valid_o),
    .trap_cause_o(trap_cause_o), .instret_o(instret_o), .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0]       st;
    logic             req;
    logic             we;
    logic             asel;
    logic             irwe;
    logic             rfwe;
    logic [1:0]       src;
    logic             csrwe;
    logic             pcwe;
    logic [1:0]       psel;
    logic             tv;
    logic [1:0]       tc;
    logic [CNT_W-1:0] ir;
  } exp_t;

  exp_t       exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         passes = 0;
  int         exp_ir = 0;
  string      cur_tag = "";
  logic [3:0] cur_op = 4'd0;
  logic [3:0] cur_sk = 4'd0;
  exp_t       mon_e, mon_a;
  string      mon_t;

  function automatic exp_t ex(input int st, input bit req, input bit we, input bit asel,
                              input bit irwe, input bit rfwe, input int src, input bit csrwe,
                              input bit pcwe, input int psel, input bit tv, input int tc);
    exp_t e;
    e.st = 3'(st); e.req = req; e.we = we; e.asel = asel; e.irwe = irwe; e.rfwe = rfwe;
    e.src = 2'(src); e.csrwe = csrwe; e.pcwe = pcwe; e.psel = 2'(psel); e.tv = tv;
    e.tc = 2'(tc); e.ir = CNT_W'(exp_ir);
    return e;
  endfunction

  function automatic exp_t e_idle(input int st);
    return ex(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic exp_t e_fetch();
    return ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic exp_t e_fwait(input bit irwe);
    return ex(1, 0, 0, 0, irwe, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic exp_t e_mem(input bit we);
    return ex(4, 1, we, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic exp_t e_pc(input int st, input int psel);
    return ex(st, 0, 0, 0, 0, 0, 0, 0, 1, psel, 0, 0);
  endfunction
  function automatic exp_t e_wb(input bit rfwe, input int src, input bit csrwe, input int psel);
    return ex(6, 0, 0, 0, 0, rfwe, src, csrwe, 1, psel, 0, 0);
  endfunction
  function automatic exp_t e_trap(input int tc);
    return ex(7, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, tc);
  endfunction

  // One clock cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input bit r, input bit g, input bit v, input bit bt, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; mem_gnt_i = g; mem_rvalid_i = v; branch_taken_i = bt;
    opcode_i = cur_op; sys_kind_i = cur_sk;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
  endtask

  task automatic fetch_dec();
    step(0, 1, 0, 0, e_fetch());
    step(0, 0, 1, 0, e_fwait(1));
    step(0, 0, 0, 0, e_idle(2));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a.st = state_o; mon_a.req = mem_req_o; mon_a.we = mem_we_o; mon_a.asel = mem_addr_sel_o;
      mon_a.irwe = ir_we_o; mon_a.rfwe = rf_we_o; mon_a.src = rf_src_o; mon_a.csrwe = csr_we_o;
      mon_a.pcwe = pc_we_o; mon_a.psel = pc_sel_o; mon_a.tv = trap_valid_o;
      mon_a.tc = trap_cause_o; mon_a.ir = instret_o;
      checks++;
      if (mon_a !== mon_e) begin
        $display("FAIL %s: got st=%0d vec=%h instret=%0d, expected st=%0d vec=%h instret=%0d",
                 mon_t, mon_a.st, mon_a[CNT_W+17:CNT_W], mon_a.ir,
                 mon_e.st, mon_e[CNT_W+17:CNT_W], mon_e.ir);
      end else begin
        passes++;
        $display("chk %-10s st=%0d instret=%0d ok", mon_t, mon_a.st, mon_a.ir);
      end
    end
  end

  initial begin
    cur_tag = "reset";
    step(1, 0, 0, 0, e_idle(0));
    step(1, 0, 0, 0, e_idle(0));

    cur_tag = "addi"; cur_op = 4'd8;
    fetch_dec();
    step(0, 0, 0, 0, e_idle(3));
    step(0, 0, 0, 0, e_wb(1, 0, 0, 0));
    exp_ir++;

    cur_tag = "lw"; cur_op = 4'd6;
    fetch_dec();
    step(0, 0, 0, 0, e_idle(3));
    step(0, 0, 0, 0, e_mem(0));
    step(0, 0, 0, 0, e_mem(0));
    step(0, 0, 0, 0, e_mem(0));
    step(0, 1, 0, 0, e_mem(0));
    step(0, 0, 0, 0, e_idle(5));
    step(0, 0, 1, 0, e_idle(5));
    step(0, 0, 0, 0, e_wb(1, 1, 0, 0));
    exp_ir++;

    cur_tag = "beq_taken"; cur_op = 4'd5;
    fetch_dec();
    step(0, 0, 0, 1, e_pc(3, 1));
    exp_ir++;

    cur_tag = "beq_not"; cur_op = 4'd5;
    fetch_dec();
    step(0, 0, 0, 0, e_pc(3, 0));
    exp_ir++;

    cur_tag = "illegal"; cur_op = 4'd0;
    fetch_dec();
    step(0, 0, 0, 0, e_trap(0));

    cur_tag = "ebreak"; cur_op = 4'd11; cur_sk = 4'd2;
    fetch_dec();
    step(0, 0, 0, 0, e_trap(2));

    cur_tag = "csrrw"; cur_op = 4'd11; cur_sk = 4'd3;
    fetch_dec();
    step(0, 0, 0, 0, e_idle(3));
    step(0, 0, 0, 0, e_wb(1, 3, 1, 0));
    exp_ir++;

    cur_tag = "jal"; cur_op = 4'd3; cur_sk = 4'd0;
    fetch_dec();
    step(0, 0, 0, 0, e_idle(3));
    step(0, 0, 0, 0, e_wb(1, 2, 0, 1));
    exp_ir++;

    cur_tag = "fence"; cur_op = 4'd10;
    fetch_dec();
    step(0, 0, 0, 0, e_wb(0, 0, 0, 0));
    exp_ir++;

    cur_tag = "sw"; cur_op = 4'd7;
    fetch_dec();
    step(0, 0, 0, 0, e_idle(3));
    step(0, 1, 0, 0, e_mem(1));
    step(0, 0, 1, 0, e_pc(5, 0));
    exp_ir++;

    cur_tag = "timeout";
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, e_fetch());
    step(0, 0, 0, 0, e_trap(3));

    cur_tag = "gnt_last";
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, e_fetch());
    step(0, 1, 0, 0, e_fetch());
    step(0, 0, 1, 0, e_fwait(1));
    step(0, 0, 0, 0, e_idle(2));
    step(0, 0, 0, 0, e_idle(3));
    step(0, 1, 0, 0, e_mem(1));
    step(0, 0, 0, 0, e_idle(5));

    cur_tag = "mid_reset";
    exp_ir = 0;
    step(1, 0, 1, 0, e_idle(0));
    step(0, 0, 1, 0, e_fetch());
    step(0, 0, 1, 0, e_fetch());
    step(0, 1, 0, 0, e_fetch());
    step(0, 0, 0, 0, e_fwait(0));

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
